// File: rtl/power_seq_pkg.sv
// Shared types and sizes for the power-analysis trace sequencer.
package power_seq_pkg;

  localparam int GAP_W_DEF   = 8;
  localparam int RND_W_DEF   = 4;
  localparam int TRACE_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GAP     = 3'd1,
    CLEAR   = 3'd2,
    ADVANCE = 3'd3,
    LOAD    = 3'd4,
    ROUND   = 3'd5
  } state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that saturates at zero and flags when it is empty.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/power_trace_sequencer.sv
// Cycle-exact controller for the 4-S-box trace datapath: sequences clear, LFSR
// advance, load and round enables, and counts completed traces.
module power_trace_sequencer
  import power_seq_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF,
  parameter int RND_W = RND_W_DEF
) (
  input  logic                   ICE_CLK,
  input  logic                   reset,
  input  logic                   free_run,
  input  logic                   start,
  input  logic [GAP_W-1:0]       gap_len,
  input  logic [RND_W-1:0]       num_rounds,
  output logic                   text_clr,
  output logic                   lfsr_shift_en,
  output logic                   text_reg_en,
  output logic                   text_in_sel,
  output logic                   trigger,
  output logic                   busy,
  output logic                   done,
  output logic [TRACE_CNT_W-1:0] trace_count,
  output state_t                 dbg_state
);

  state_t                 r_state;
  state_t                 w_next;
  logic [TRACE_CNT_W-1:0] r_trace_count;
  logic                   w_gap_load;
  logic                   w_gap_dec;
  logic                   w_gap_zero;
  logic [GAP_W-1:0]       w_gap_init;
  logic                   w_rnd_load;
  logic                   w_rnd_dec;
  logic                   w_rnd_zero;
  logic [RND_W-1:0]       w_rnd_init;
  logic                   w_done;

  // A GAP of N cycles runs the counter N-1 .. 0; gap_len=0 still gives one cycle.
  assign w_gap_init = gap_len - GAP_W'(gap_len != '0);
  assign w_rnd_init = num_rounds - RND_W'(num_rounds != '0);

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (ICE_CLK),
    .rst        (reset),
    .i_load     (w_gap_load),
    .i_load_val (w_gap_init),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  // Round count is captured on LOAD entry and decremented from LOAD onwards, so
  // done is a pure decode of registered state during LOAD and ROUND.
  seq_down_counter #(.W(RND_W)) u_rnd_cnt (
    .clk        (ICE_CLK),
    .rst        (reset),
    .i_load     (w_rnd_load),
    .i_load_val (w_rnd_init),
    .i_dec      (w_rnd_dec),
    .o_zero     (w_rnd_zero)
  );

  assign w_done = ((r_state == LOAD) || (r_state == ROUND)) && w_rnd_zero;

  always_ff @(posedge ICE_CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_gap_load = 1'b0;
    w_gap_dec  = 1'b0;
    w_rnd_load = 1'b0;
    w_rnd_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start || free_run) begin
          w_next     = GAP;
          w_gap_load = 1'b1;
        end
      end
      GAP: begin
        if (w_gap_zero) w_next = CLEAR;
        else            w_gap_dec = 1'b1;
      end
      CLEAR:   w_next = ADVANCE;
      ADVANCE: begin
        w_next     = LOAD;
        w_rnd_load = 1'b1;
      end
      LOAD: begin
        w_rnd_dec = 1'b1;
        w_next    = ROUND;
      end
      ROUND:   w_rnd_dec = 1'b1;
      default: w_next = IDLE;
    endcase
    if (w_done) begin
      w_next     = free_run ? GAP : IDLE;
      w_gap_load = free_run;
    end
  end

  always_ff @(posedge ICE_CLK or posedge reset) begin
    if (reset) begin
      r_trace_count <= '0;
    end else if (w_done) begin
      r_trace_count <= r_trace_count + TRACE_CNT_W'(1);
    end
  end

  assign text_clr      = (r_state == CLEAR);
  assign lfsr_shift_en = (r_state == ADVANCE);
  assign text_reg_en   = (r_state == LOAD) || (r_state == ROUND);
  assign text_in_sel   = (r_state == ROUND);
  assign trigger       = text_reg_en;
  assign busy          = (r_state != IDLE);
  assign done          = w_done;
  assign trace_count   = r_trace_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_power_trace_sequencer.sv
// Self-checking bench for power_trace_sequencer: per-cycle output vectors are
// queued from the trace-length rules and compared against the DUT.
module tb_power_trace_sequencer;
  import power_seq_pkg::*;

  logic        ICE_CLK = 1'b0;
  logic        reset;
  logic        free_run;
  logic        start;
  logic [7:0]  gap_len;
  logic [3:0]  num_rounds;
  logic        text_clr;
  logic        lfsr_shift_en;
  logic        text_reg_en;
  logic        text_in_sel;
  logic        trigger;
  logic        busy;
  logic        done;
  logic [15:0] trace_count;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;

  // {busy, text_clr, lfsr_shift_en, text_reg_en, text_in_sel, trigger, done}
  logic [6:0]  w_obs;
  logic [6:0]  exp_q[$];
  logic [15:0] cnt_q[$];
  logic [15:0] exp_cnt;

  assign w_obs = {busy, text_clr, lfsr_shift_en, text_reg_en, text_in_sel, trigger, done};

  power_trace_sequencer #(.GAP_W(8), .RND_W(4)) dut (
    .ICE_CLK       (ICE_CLK),
    .reset         (reset),
    .free_run      (free_run),
    .start         (start),
    .gap_len       (gap_len),
    .num_rounds    (num_rounds),
    .text_clr      (text_clr),
    .lfsr_shift_en (lfsr_shift_en),
    .text_reg_en   (text_reg_en),
    .text_in_sel   (text_in_sel),
    .trigger       (trigger),
    .busy          (busy),
    .done          (done),
    .trace_count   (trace_count),
    .dbg_state     (dbg_state)
  );

  always #5 ICE_CLK = ~ICE_CLK;

  task automatic push_trace(input int gap, input int nr);
    int g;
    int r;
    g = (gap == 0) ? 1 : gap;
    r = (nr == 0) ? 1 : nr;
    for (int i = 0; i < g; i++) exp_q.push_back(7'b1000000);
    exp_q.push_back(7'b1100000);
    exp_q.push_back(7'b1010000);
    for (int i = 0; i < r; i++)
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, (i != 0), 1'b1, (i == r - 1)});
    exp_cnt = exp_cnt + 16'd1;
    cnt_q.push_back(exp_cnt);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(7'b0000000);
  endtask

  task automatic test_reset();
    logic [6:0] exp_v;
    int cyc;
    reset = 1'b1; free_run = 1'b0; start = 1'b0; gap_len = 8'd0; num_rounds = 4'd0;
    exp_cnt = 16'd0;
    repeat (3) @(negedge ICE_CLK);
    reset = 1'b0;
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    checks++;
    if (trace_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %h want 0000", trace_count);
    end
    push_idle(20);
    cyc = 0;
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, w_obs, exp_v);
      end
      @(negedge ICE_CLK);
      cyc++;
    end
  endtask

  task automatic test_free_run();
    logic [6:0] exp_v;
    int cyc;
    gap_len = 8'd10; num_rounds = 4'd4;
    free_run = 1'b1;
    @(negedge ICE_CLK);
    for (int t = 0; t < 3; t++) push_trace(10, 4);
    push_idle(2);
    cyc = 0;
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL free_run cyc %0d: got %b want %b", cyc, w_obs, exp_v);
      end
      if (cyc == 40) free_run = 1'b0;
      @(negedge ICE_CLK);
      if (exp_v[0]) begin
        checks++;
        if (trace_count !== cnt_q[0]) begin
          errors++; $display("FAIL free_run_count cyc %0d: got %h want %h", cyc, trace_count, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
      end
      cyc++;
    end
  endtask

  task automatic test_single_min();
    logic [6:0] exp_v;
    int cyc;
    int n_busy;
    gap_len = 8'd0; num_rounds = 4'd0;
    start = 1'b1;
    @(negedge ICE_CLK);
    start = 1'b0;
    push_trace(0, 0);
    push_idle(3);
    cyc = 0;
    n_busy = 0;
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL single_min cyc %0d: got %b want %b", cyc, w_obs, exp_v);
      end
      if (busy === 1'b1) n_busy++;
      @(negedge ICE_CLK);
      if (exp_v[0]) begin
        checks++;
        if (trace_count !== cnt_q[0]) begin
          errors++; $display("FAIL single_min_count: got %h want %h", trace_count, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
      end
      cyc++;
    end
    checks++;
    if (n_busy != 4) begin
      errors++; $display("FAIL single_min_busy: got %0d cycles want 4", n_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_v;
    int cyc;
    gap_len = 8'd5; num_rounds = 4'd2;
    start = 1'b1;
    @(negedge ICE_CLK);
    start = 1'b0;
    push_trace(5, 2);
    push_idle(4);
    cyc = 0;
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %b want %b", cyc, w_obs, exp_v);
      end
      start = (cyc < 6) && (cyc % 2 == 0);
      if (cyc == 1) gap_len = 8'd2;
      @(negedge ICE_CLK);
      if (exp_v[0]) begin
        checks++;
        if (trace_count !== cnt_q[0]) begin
          errors++; $display("FAIL back_to_back_count: got %h want %h", trace_count, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_round();
    logic [6:0] exp_v;
    int cyc;
    gap_len = 8'd2; num_rounds = 4'd6;
    start = 1'b1;
    @(negedge ICE_CLK);
    start = 1'b0;
    push_trace(2, 6);
    for (cyc = 0; cyc < 7; cyc++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL abort_pre cyc %0d: got %b want %b", cyc, w_obs, exp_v);
      end
      @(negedge ICE_CLK);
    end
    checks++;
    if (dbg_state !== ROUND) begin
      errors++; $display("FAIL abort_in_round: got %0d want %0d", dbg_state, ROUND);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (w_obs !== 7'b0000000) begin
      errors++; $display("FAIL abort_outputs: got %b want 0000000", w_obs);
    end
    checks++;
    if (dbg_state !== IDLE || trace_count !== 16'd0) begin
      errors++; $display("FAIL abort_state: got state %0d count %h want %0d 0000", dbg_state, trace_count, IDLE);
    end
    exp_q.delete();
    cnt_q.delete();
    exp_cnt = 16'd0;
    @(negedge ICE_CLK);
    reset = 1'b0;
    push_idle(6);
    cyc = 0;
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v || trace_count !== exp_cnt) begin
        errors++; $display("FAIL abort_post cyc %0d: got %b/%h want %b/%h", cyc, w_obs, trace_count, exp_v, exp_cnt);
      end
      @(negedge ICE_CLK);
      cyc++;
    end
  endtask

  task automatic test_count_wrap();
    logic [6:0] exp_v;
    int cyc;
    force dut.r_trace_count = 16'hFFFF;
    @(negedge ICE_CLK);
    release dut.r_trace_count;
    @(negedge ICE_CLK);
    exp_cnt = 16'hFFFF;
    checks++;
    if (trace_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h want ffff", trace_count);
    end
    gap_len = 8'd1; num_rounds = 4'd1;
    start = 1'b1;
    @(negedge ICE_CLK);
    start = 1'b0;
    push_trace(1, 1);
    push_idle(2);
    cyc = 0;
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (w_obs !== exp_v) begin
        errors++; $display("FAIL wrap cyc %0d: got %b want %b", cyc, w_obs, exp_v);
      end
      @(negedge ICE_CLK);
      if (exp_v[0]) begin
        checks++;
        if (trace_count !== 16'h0000 || trace_count !== cnt_q[0]) begin
          errors++; $display("FAIL wrap_count: got %h want %h", trace_count, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_min();
    test_back_to_back();
    test_reset_mid_round();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
